// File: rtl/mem_unit_3_ctrl.sv
// Address/enable controller shared by three feature-map memories: fills them two pixels
// per beat, then drains them two pixels per issue with a 1-cycle registered read-valid.
module mem_unit_3_ctrl #(
    parameter int unsigned IFM_SIZE         = 16,
    parameter int unsigned ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_write,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        start_read,
    input  logic                        rd_pause,
    output logic [ADDRESS_SIZE_IFM-1:0] Address_A,
    output logic [ADDRESS_SIZE_IFM-1:0] Address_B,
    output logic                        Enable_Write_A_Mem,
    output logic                        Enable_Write_B_Mem,
    output logic                        Enable_Read_A_Mem,
    output logic                        Enable_Read_B_Mem,
    output logic                        rd_valid,
    output logic                        rd_last,
    output logic                        wr_done,
    output logic                        rd_done,
    output logic                        busy
);

    localparam logic [ADDRESS_SIZE_IFM-1:0] LastAddr = ADDRESS_SIZE_IFM'(IFM_SIZE * IFM_SIZE - 2);
    localparam logic [ADDRESS_SIZE_IFM-1:0] AddrOne  = ADDRESS_SIZE_IFM'(1);
    localparam logic [ADDRESS_SIZE_IFM-1:0] AddrTwo  = ADDRESS_SIZE_IFM'(2);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StFull,
        StRead,
        StDrain
    } state_e;

    state_e                      r_state;
    state_e                      w_state_next;
    logic [ADDRESS_SIZE_IFM-1:0] r_wr_ptr;
    logic [ADDRESS_SIZE_IFM-1:0] w_wr_ptr_next;
    logic [ADDRESS_SIZE_IFM-1:0] r_rd_ptr;
    logic [ADDRESS_SIZE_IFM-1:0] w_rd_ptr_next;
    logic                        r_rd_valid;
    logic                        r_rd_last;
    logic                        r_wr_done;
    logic                        w_wr_beat;
    logic                        w_rd_issue;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_wr_done  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            // Memory read data arrives one cycle after the issue, so qualifiers trail by one.
            r_rd_valid <= w_rd_issue;
            r_rd_last  <= w_rd_issue && (r_rd_ptr == LastAddr);
            r_wr_done  <= w_wr_beat && (r_wr_ptr == LastAddr);
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_wr_ptr_next      = r_wr_ptr;
        w_rd_ptr_next      = r_rd_ptr;
        w_wr_beat          = 1'b0;
        w_rd_issue         = 1'b0;
        in_ready           = 1'b0;
        Enable_Write_A_Mem = 1'b0;
        Enable_Write_B_Mem = 1'b0;
        Enable_Read_A_Mem  = 1'b0;
        Enable_Read_B_Mem  = 1'b0;
        Address_A          = '0;
        Address_B          = '0;
        rd_done            = 1'b0;
        busy               = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (start_write) begin
                    w_state_next  = StWrite;
                    w_wr_ptr_next = '0;
                end
            end
            StWrite: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    w_wr_beat          = 1'b1;
                    Enable_Write_A_Mem = 1'b1;
                    Enable_Write_B_Mem = 1'b1;
                    Address_A          = r_wr_ptr;
                    Address_B          = r_wr_ptr + AddrOne;
                    if (r_wr_ptr == LastAddr) begin
                        w_state_next  = StFull;
                        w_wr_ptr_next = '0;
                    end else begin
                        w_wr_ptr_next = r_wr_ptr + AddrTwo;
                    end
                end
            end
            StFull: begin
                // A drain request takes priority over a refill.
                if (start_read) begin
                    w_state_next  = StRead;
                    w_rd_ptr_next = '0;
                end else if (start_write) begin
                    w_state_next  = StWrite;
                    w_wr_ptr_next = '0;
                end
            end
            StRead: begin
                busy = 1'b1;
                if (!rd_pause) begin
                    w_rd_issue        = 1'b1;
                    Enable_Read_A_Mem = 1'b1;
                    Enable_Read_B_Mem = 1'b1;
                    Address_A         = r_rd_ptr;
                    Address_B         = r_rd_ptr + AddrOne;
                    if (r_rd_ptr == LastAddr) begin
                        w_state_next  = StDrain;
                        w_rd_ptr_next = '0;
                    end else begin
                        w_rd_ptr_next = r_rd_ptr + AddrTwo;
                    end
                end
            end
            StDrain: begin
                busy         = 1'b1;
                rd_done      = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign rd_valid = r_rd_valid;
    assign rd_last  = r_rd_last;
    assign wr_done  = r_wr_done;

endmodule

// File: tb/tb_mem_unit_3_ctrl.sv
// Directed bench for mem_unit_3_ctrl at IFM_SIZE=4: a vector table for a full fill/drain
// pass, plus hand sequences for gapped writes, read pause and reset mid-fill.
module tb_mem_unit_3_ctrl;

    localparam int unsigned Ifm = 4;
    localparam int unsigned Aw  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_write = 1'b0;
    logic          in_valid = 1'b0;
    logic          start_read = 1'b0;
    logic          rd_pause = 1'b0;
    logic          in_ready;
    logic [Aw-1:0] Address_A;
    logic [Aw-1:0] Address_B;
    logic          Enable_Write_A_Mem;
    logic          Enable_Write_B_Mem;
    logic          Enable_Read_A_Mem;
    logic          Enable_Read_B_Mem;
    logic          rd_valid;
    logic          rd_last;
    logic          wr_done;
    logic          rd_done;
    logic          busy;

    mem_unit_3_ctrl #(
        .IFM_SIZE        (Ifm),
        .ADDRESS_SIZE_IFM(Aw)
    ) u_dut (
        .clk               (clk),
        .reset             (reset),
        .start_write       (start_write),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .start_read        (start_read),
        .rd_pause          (rd_pause),
        .Address_A         (Address_A),
        .Address_B         (Address_B),
        .Enable_Write_A_Mem(Enable_Write_A_Mem),
        .Enable_Write_B_Mem(Enable_Write_B_Mem),
        .Enable_Read_A_Mem (Enable_Read_A_Mem),
        .Enable_Read_B_Mem (Enable_Read_B_Mem),
        .rd_valid          (rd_valid),
        .rd_last           (rd_last),
        .wr_done           (wr_done),
        .rd_done           (rd_done),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Flag order: in_ready, wr_a, wr_b, rd_a, rd_b, rd_valid, rd_last, wr_done, rd_done, busy
    logic [9:0] w_flags;
    assign w_flags = {in_ready, Enable_Write_A_Mem, Enable_Write_B_Mem, Enable_Read_A_Mem,
                      Enable_Read_B_Mem, rd_valid, rd_last, wr_done, rd_done, busy};

    localparam logic [9:0] FIdle   = 10'b0000000000;
    localparam logic [9:0] FWrBeat = 10'b1110000001;
    localparam logic [9:0] FWrWait = 10'b1000000001;
    localparam logic [9:0] FWrDone = 10'b0000000100;
    localparam logic [9:0] FRdIss0 = 10'b0001100001;
    localparam logic [9:0] FRdIss  = 10'b0001110001;
    localparam logic [9:0] FDrain  = 10'b0000011011;

    typedef struct {
        logic          sw;
        logic          sr;
        logic          iv;
        logic          rp;
        logic [9:0]    flags;
        logic [Aw-1:0] a;
        logic [Aw-1:0] b;
    } vec_t;

    localparam int NumVec = 24;
    vec_t vecs[NumVec];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic vec_t mk(input logic sw, input logic sr, input logic iv, input logic rp,
                                input logic [9:0] flags, input int a, input int b);
        vec_t v;
        v.sw    = sw;
        v.sr    = sr;
        v.iv    = iv;
        v.rp    = rp;
        v.flags = flags;
        v.a     = Aw'(a);
        v.b     = Aw'(b);
        return v;
    endfunction

    task automatic drive(input logic sw, input logic sr, input logic iv, input logic rp);
        @(negedge clk);
        start_write = sw;
        start_read  = sr;
        in_valid    = iv;
        rd_pause    = rp;
        #2;
    endtask

    task automatic check(input string nm, input logic [9:0] ef, input logic [Aw-1:0] ea,
                         input logic [Aw-1:0] eb);
        n_cmp++;
        if (w_flags !== ef) begin
            n_bad++;
            $display("FAIL %s flags got %b want %b", nm, w_flags, ef);
        end
        n_cmp++;
        if (Address_A !== ea || Address_B !== eb) begin
            n_bad++;
            $display("FAIL %s addr got (%0d,%0d) want (%0d,%0d)", nm, Address_A, Address_B,
                     ea, eb);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int ptr;
        logic issue;
        logic prev_issue;
        logic pause;
        int c;

        // Table: one idle check, ignored start_read, fill, wr_done, read, drain
        vecs[0] = mk(0, 0, 0, 0, FIdle, 0, 0);
        vecs[1] = mk(0, 1, 0, 0, FIdle, 0, 0);
        vecs[2] = mk(1, 1, 0, 0, FIdle, 0, 0);
        for (int k = 0; k < 8; k++) begin
            vecs[3 + k] = mk((k == 1), 0, 1, 0, FWrBeat, 2 * k, 2 * k + 1);
        end
        vecs[11] = mk(0, 0, 0, 0, FWrDone, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, FIdle, 0, 0);
        vecs[13] = mk(1, 1, 0, 0, FIdle, 0, 0);
        for (int k = 0; k < 8; k++) begin
            vecs[14 + k] = mk((k == 2), 0, 0, 0, (k == 0) ? FRdIss0 : FRdIss, 2 * k, 2 * k + 1);
        end
        vecs[22] = mk(0, 0, 0, 0, FDrain, 0, 0);
        vecs[23] = mk(0, 0, 0, 0, FIdle, 0, 0);

        // Held in reset with stimulus active: everything stays 0
        drive(1, 0, 1, 0);
        check("reset_hold0", FIdle, 0, 0);
        drive(0, 1, 1, 0);
        check("reset_hold1", FIdle, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NumVec; i++) begin
            drive(vecs[i].sw, vecs[i].sr, vecs[i].iv, vecs[i].rp);
            check($sformatf("vec%0d", i), vecs[i].flags, vecs[i].a, vecs[i].b);
        end

        // Gapped fill: beats on even cycles, address equals cycle index
        drive(1, 0, 0, 0);
        check("gap_start", FIdle, 0, 0);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, (i % 2 == 0), 0);
            if (i == 15) begin
                check("gap_done", FWrDone, 0, 0);
            end else if (i % 2 == 0) begin
                check($sformatf("gap_beat%0d", i), FWrBeat, Aw'(i), Aw'(i + 1));
            end else begin
                check($sformatf("gap_wait%0d", i), FWrWait, 0, 0);
            end
        end

        // Read with rd_pause held for cycles 3..5 after start_read
        drive(0, 1, 0, 0);
        check("pause_start", FIdle, 0, 0);
        ptr        = 0;
        prev_issue = 1'b0;
        c          = 1;
        while (ptr < Ifm * Ifm && c < 40) begin
            pause = (c >= 3 && c <= 5);
            issue = !pause;
            drive(0, 0, 0, pause);
            check($sformatf("pause_c%0d", c), {3'b000, issue, issue, prev_issue, 4'b0001},
                  issue ? Aw'(ptr) : '0, issue ? Aw'(ptr + 1) : '0);
            if (issue) ptr += 2;
            prev_issue = issue;
            c++;
        end
        drive(0, 0, 0, 0);
        check("pause_drain", FDrain, 0, 0);
        drive(0, 0, 0, 0);
        check("pause_idle", FIdle, 0, 0);

        // Reset on the 5th write beat, then a fresh fill from address 0
        drive(1, 0, 0, 0);
        check("rst_start", FIdle, 0, 0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 1, 0);
            check($sformatf("rst_beat%0d", k), FWrBeat, Aw'(2 * k), Aw'(2 * k + 1));
        end
        reset = 1'b0;
        #1;
        check("rst_async", FIdle, 0, 0);
        drive(0, 0, 1, 0);
        check("rst_held", FIdle, 0, 0);
        @(negedge clk);
        reset       = 1'b1;
        start_write = 1'b1;
        in_valid    = 1'b0;
        #2;
        check("rst_release", FIdle, 0, 0);
        drive(0, 0, 1, 0);
        check("refill_beat0", FWrBeat, 0, 1);
        drive(0, 0, 1, 0);
        check("refill_beat1", FWrBeat, 2, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_unit_3_ctrl.md
MEM_UNIT_3_CTRL -- requirements
Module: mem_unit_3_ctrl

Interface
REQ-001 Parameter IFM_SIZE, default 16, feature-map side length; IFM_SIZE*IFM_SIZE SHALL be even.
REQ-002 Parameter ADDRESS_SIZE_IFM, default $clog2(IFM_SIZE*IFM_SIZE), address width.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port start_write  input  1  one-cycle pulse that begins a fill pass.
REQ-006 Port in_valid  input  1  a pixel pair (two consecutive addresses) is present on the memory data inputs.
REQ-007 Port in_ready  output  1  controller accepts a pair this cycle.
REQ-008 Port start_read  input  1  one-cycle pulse that begins a drain pass.
REQ-009 Port rd_pause  input  1  stalls read address issue while high.
REQ-010 Port Address_A, Address_B  output  ADDRESS_SIZE_IFM each  shared addresses to all three memories.
REQ-011 Port Enable_Write_A_Mem, Enable_Write_B_Mem, Enable_Read_A_Mem, Enable_Read_B_Mem  output  1 each  memory port enables.
REQ-012 Port rd_valid  output  1  memory data outputs hold valid pair this cycle.
REQ-013 Port rd_last  output  1  qualifies the final valid pair.
REQ-014 Port wr_done, rd_done  output  1 each  one-cycle completion pulses.
REQ-015 Port busy  output  1  high in any state except IDLE and FULL.

Function
REQ-016 States SHALL be IDLE, WRITE, FULL, READ, DRAIN; pointers wr_ptr, rd_ptr step by 2.
REQ-017 IDLE: start_write -> WRITE with wr_ptr=0; start_read ignored; start_write and start_read together -> WRITE.
REQ-018 WRITE: in_ready=1; a beat fires when in_valid&in_ready; on a beat Enable_Write_A_Mem=Enable_Write_B_Mem=1 in the same cycle (combinational), Address_A=wr_ptr, Address_B=wr_ptr+1, wr_ptr+=2.
REQ-019 WRITE with in_valid=0: both write enables 0, wr_ptr holds, no timeout.
REQ-020 Beat at wr_ptr=IFM_SIZE*IFM_SIZE-2 -> FULL next cycle, wr_done=1 for exactly that cycle, wr_ptr wraps to 0.
REQ-021 FULL: in_ready=0; start_write -> WRITE (refill, overwrite); start_read -> READ with rd_ptr=0; start_read wins if both.
REQ-022 READ: if rd_pause=0, Enable_Read_A_Mem=Enable_Read_B_Mem=1, Address_A=rd_ptr, Address_B=rd_ptr+1, rd_ptr+=2; if rd_pause=1, read enables 0, rd_ptr holds.
REQ-023 rd_valid SHALL be a register equal to the previous cycle's read-issue (1-cycle memory read latency); rd_last likewise registered for the issue at rd_ptr=IFM_SIZE*IFM_SIZE-2.
REQ-024 Issue at last address -> DRAIN; DRAIN issues nothing, asserts rd_valid/rd_last from the final issue, pulses rd_done, returns to IDLE next cycle.
REQ-025 Write enables SHALL never be high outside WRITE; read enables never high outside READ; read and write enables never high together.
REQ-026 Outside active issue, Address_A/Address_B SHALL be 0.
REQ-027 start_write/start_read received in WRITE, READ or DRAIN SHALL be ignored.

Reset
REQ-028 reset low SHALL asynchronously force state IDLE, pointers 0, and every output 0 (in_ready, enables, addresses, rd_valid, rd_last, wr_done, rd_done, busy).
REQ-029 Reset mid-WRITE or mid-READ SHALL abort the pass; no pulse is emitted; memory contents are undefined afterwards.
REQ-030 After reset deassertion the controller SHALL accept start_write on the first rising edge.

Verification
REQ-031 IFM_SIZE=4: start_write, 8 back-to-back beats -> addresses (0,1),(2,3)..(14,15), wr_done on cycle after 8th beat, state FULL.
REQ-032 Fill with in_valid toggling 1,0,1,0 -> 8 beats over 16 cycles, no write enable on idle cycles, addresses contiguous.
REQ-033 FULL, start_read, no pause -> 8 read issues, rd_valid high cycles 2..9 after start, rd_last on 9th, rd_done in DRAIN, then IDLE.
REQ-034 READ with rd_pause high 3 cycles after 2nd issue -> rd_ptr holds at 4, rd_valid low for 3 cycles, sequence resumes at (4,5).
REQ-035 start_read in IDLE and start_write during READ -> ignored, no enable activity change.
REQ-036 reset asserted at 5th write beat -> all outputs 0 asynchronously, no wr_done; fresh fill then starts at address 0.
